flow_usage_tracker: RTL
=======================

FLOW_USAGE_TRACKER -- requirements
Module: flow_usage_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 6, width of per-user usage/quota words.
REQ-002 SHALL have parameter NUM_USERS, default 4, number of users/zones; user_select is 2 bits, so the legal range is NUM_USERS <= 4.
REQ-003 SHALL have parameter DEBOUNCE_WIDTH, default 8, debounce counter width; stability threshold T = 2^DEBOUNCE_WIDTH-1 cycles.
REQ-004 SHALL have parameter QUOTA_INIT, default 40, reset value of every quota word.
REQ-005 clk  in  1  single system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 flow_pulse_raw  in  1  asynchronous, bouncy flow-meter pulse.
REQ-008 valve_on  in  1  valve state, fed back from the downstream irrigation core.
REQ-009 user_select  in  2  user credited with flow; also the target for reset_user and quota_wr.
REQ-010 reset_user  in  1  clears the selected user's usage.
REQ-011 quota_wr  in  1  writes quota_set into the selected user's quota.
REQ-012 quota_set  in  WIDTH  new quota value.
REQ-013 usage  out  NUM_USERS*WIDTH  flat usage table; user k occupies bits [k*WIDTH +: WIDTH].
REQ-014 quota  out  NUM_USERS*WIDTH  flat quota table, same packing as usage.
REQ-015 flow_tick  out  1  one-cycle strobe per debounced rising edge.
REQ-016 usage_sat  out  NUM_USERS  per user: usage is at all-ones.
REQ-017 leak_alarm  out  1  sticky flag: flow detected while the valve is closed.

Function
REQ-018 SHALL synchronise flow_pulse_raw through 2 flops (sync_q) before any other use.
REQ-019 Debounce SHALL be a 4-state FSM: LOW, CHK_HIGH, HIGH, CHK_LOW.
- LOW->CHK_HIGH when sync_q=1; CHK_HIGH->LOW when sync_q=0.
- CHK_HIGH->HIGH after T consecutive cycles of sync_q=1.
- HIGH/CHK_LOW transitions are symmetric.
- The counter clears on every state entry.
REQ-020 flow_tick SHALL be high for exactly one cycle on each LOW-side->HIGH transition; no tick on the falling side.
REQ-021 Latency: raw held high from cycle n SHALL produce flow_tick high in cycle n+2+T; any glitch shorter than T cycles SHALL produce no tick.
REQ-022 On flow_tick, usage[user_select] SHALL increment by 1 and saturate at 2^WIDTH-1 (no wrap).
- user_select is sampled in the tick cycle.
- An out-of-range user_select (>= NUM_USERS) SHALL be ignored.
REQ-023 reset_user SHALL set usage[user_select] to 0 next cycle and SHALL win over a simultaneous tick for the same user.
REQ-024 quota_wr SHALL load quota[user_select] next cycle, independent of and concurrent with reset_user and tick.
REQ-025 usage_sat[k] SHALL be the combinational compare of usage[k] against all-ones.
REQ-026 leak_alarm SHALL set on a flow_tick with valve_on=0 and hold until rst; the usage credit still occurs.
REQ-027 usage and quota SHALL be registered outputs: 1-cycle update latency, no combinational path from inputs.

Reset
REQ-028 rst SHALL, synchronously:
- force the FSM to LOW and clear the debounce counter and both sync flops;
- clear all usage words, flow_tick and leak_alarm;
- load every quota word with QUOTA_INIT.
REQ-029 rst asserted mid-debounce or mid-bounce SHALL abort with no tick emitted; rst SHALL override all other inputs.

Structure
REQ-030 WIDTH, NUM_USERS and QUOTA_INIT defaults, plus the debounce state enum, SHALL live in the shared package irrig_pkg.
REQ-031 The debounce FSM SHALL be a sub-module, pulse_debouncer (in: clk, rst, raw; out: tick), instantiated once.

Verification (DEBOUNCE_WIDTH=2, T=3)
REQ-032 After rst: quota all 40, usage all 0, leak_alarm 0, flow_tick 0.
REQ-033 raw high from cycle 10 -> single flow_tick at cycle 15; user_select=2, valve_on=1 -> usage[2]=1, leak_alarm stays 0.
REQ-034 raw pulses 1-2 cycles wide (bounce) -> no flow_tick and usage unchanged.
REQ-035 Apply 70 ticks to user 1 -> usage[1]=63, usage_sat[1]=1, no wrap.
REQ-036 reset_user and tick to user 0 in the same cycle with usage[0]=5 -> usage[0]=0; quota_wr with quota_set=12, user 3 -> quota[3]=12.
REQ-037 Tick with valve_on=0 -> leak_alarm=1 and it stays set until rst; rst asserted during CHK_HIGH -> no tick afterwards.

Source files
------------

// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation flow tracking blocks.
// Holds the default datapath sizes and the debounce FSM state encoding.
package irrig_pkg;

    localparam int unsigned DEF_WIDTH      = 6;
    localparam int unsigned DEF_NUM_USERS  = 4;
    localparam int unsigned DEF_QUOTA_INIT = 40;

    // LOW side is StLow/StChkHigh, HIGH side is StHigh/StChkLow.
    typedef enum logic [1:0] {
        StLow,
        StChkHigh,
        StHigh,
        StChkLow
    } deb_state_e;

endpackage

// File: rtl/pulse_debouncer.sv
// Two-flop synchroniser followed by a 4-state debounce FSM.
// A level must hold for T = 2^DEBOUNCE_WIDTH-1 consecutive synchronised
// cycles before the FSM changes side; tick pulses for one cycle on each
// LOW-side to HIGH transition.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   raw  : asynchronous, bouncy input pulse
//   tick : registered one-cycle strobe per debounced rising edge
module pulse_debouncer import irrig_pkg::*; #(
    parameter int unsigned DEBOUNCE_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic tick
);

    // The cycle in which the FSM leaves StLow/StHigh already counts as one
    // stable cycle, so the check state needs T-1 more: counts 0 .. T-2.
    localparam bit DIRECT = (DEBOUNCE_WIDTH == 1);
    localparam logic [DEBOUNCE_WIDTH-1:0] LAST_CNT =
        DIRECT ? '0 : DEBOUNCE_WIDTH'((1 << DEBOUNCE_WIDTH) - 3);

    logic                      sync_meta_q;
    logic                      sync_q;
    deb_state_e                state_q;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q;
    logic                      tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            state_q     <= StLow;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
        end else begin
            sync_meta_q <= raw;
            sync_q      <= sync_meta_q;
            tick_q      <= 1'b0;
            unique case (state_q)
                StLow: begin
                    if (sync_q) begin
                        cnt_q <= '0;
                        if (DIRECT) begin
                            state_q <= StHigh;
                            tick_q  <= 1'b1;
                        end else begin
                            state_q <= StChkHigh;
                        end
                    end
                end
                StChkHigh: begin
                    if (!sync_q) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        tick_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (!sync_q) begin
                        cnt_q <= '0;
                        if (DIRECT) begin
                            state_q <= StLow;
                        end else begin
                            state_q <= StChkLow;
                        end
                    end
                end
                StChkLow: begin
                    if (sync_q) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/flow_usage_tracker.sv
// Per-user water usage accounting driven by a debounced flow-meter pulse.
// Each debounced flow tick credits the selected user (saturating), a sticky
// leak alarm flags flow seen while the valve is closed, and per-user quota
// words are host-writable.
//   clk, rst       : clock and synchronous active-high reset
//   flow_pulse_raw : asynchronous bouncy flow-meter pulse
//   valve_on       : valve state from the downstream irrigation core
//   user_select    : user credited with flow, and target of reset_user/quota_wr
//   reset_user     : clear selected user's usage (wins over a tick)
//   quota_wr       : load quota_set into selected user's quota
//   usage, quota   : flat registered tables, user k at [k*WIDTH +: WIDTH]
//   flow_tick      : one-cycle strobe per debounced rising edge
//   usage_sat      : per-user usage-at-all-ones flag
//   leak_alarm     : sticky flow-while-valve-closed flag
module flow_usage_tracker import irrig_pkg::*; #(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned NUM_USERS      = DEF_NUM_USERS,
    parameter int unsigned DEBOUNCE_WIDTH = 8,
    parameter int unsigned QUOTA_INIT     = DEF_QUOTA_INIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flow_pulse_raw,
    input  logic                       valve_on,
    input  logic [1:0]                 user_select,
    input  logic                       reset_user,
    input  logic                       quota_wr,
    input  logic [WIDTH-1:0]           quota_set,
    output logic [NUM_USERS*WIDTH-1:0] usage,
    output logic [NUM_USERS*WIDTH-1:0] quota,
    output logic                       flow_tick,
    output logic [NUM_USERS-1:0]       usage_sat,
    output logic                       leak_alarm
);

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] QUOTA_RST = WIDTH'(QUOTA_INIT);

    logic [WIDTH-1:0] usage_q [NUM_USERS];
    logic [WIDTH-1:0] usage_d [NUM_USERS];
    logic [WIDTH-1:0] quota_q [NUM_USERS];
    logic [WIDTH-1:0] quota_d [NUM_USERS];
    logic             leak_q;
    logic             leak_d;

    pulse_debouncer #(
        .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
    ) u_debouncer (
        .clk  (clk),
        .rst  (rst),
        .raw  (flow_pulse_raw),
        .tick (flow_tick)
    );

    // A user_select value with no matching index (>= NUM_USERS) hits no row.
    always_comb begin
        for (int unsigned k = 0; k < NUM_USERS; k++) begin
            usage_d[k] = usage_q[k];
            quota_d[k] = quota_q[k];
            if (user_select == 2'(k)) begin
                if (reset_user) begin
                    usage_d[k] = '0;
                end else if (flow_tick && (usage_q[k] != ALL_ONES)) begin
                    usage_d[k] = usage_q[k] + 1'b1;
                end
                if (quota_wr) begin
                    quota_d[k] = quota_set;
                end
            end
        end
        leak_d = leak_q | (flow_tick & ~valve_on);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_USERS; k++) begin
                usage_q[k] <= '0;
                quota_q[k] <= QUOTA_RST;
            end
            leak_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_USERS; k++) begin
                usage_q[k] <= usage_d[k];
                quota_q[k] <= quota_d[k];
            end
            leak_q <= leak_d;
        end
    end

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_pack
        assign usage[g*WIDTH +: WIDTH] = usage_q[g];
        assign quota[g*WIDTH +: WIDTH] = quota_q[g];
        assign usage_sat[g]            = (usage_q[g] == ALL_ONES);
    end

    assign leak_alarm = leak_q;

endmodule
